// File: rtl/dtree_multi_if.sv
// Feature handshake, node-table configuration and classification result
// signals of dtree_multi; master drives features/config, slave is the block.
interface dtree_multi_if #(
    parameter int FEATURES    = 3,
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4,
    parameter int DEPTH       = 2,
    parameter int CHAN_WIDTH  = 2
);
    localparam int NODES  = (1 << DEPTH) - 1;
    localparam int ACC_W  = IN_WIDTH + COEFF_WIDTH + $clog2(FEATURES) + 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SEL_W  = $clog2(FEATURES + 2);

    logic                  ready;
    logic                  in_valid;
    logic [IN_WIDTH-1:0]   sample;
    logic [CHAN_WIDTH-1:0] in_chan;
    logic                  cfg_we;
    logic [NODE_W-1:0]     cfg_node;
    logic [SEL_W-1:0]      cfg_sel;
    logic [ACC_W-1:0]      cfg_data;
    logic [LVL_W-1:0]      level;
    logic [DEPTH-1:0]      path;
    logic [CHAN_WIDTH-1:0] out_chan;
    logic                  out_valid;

    modport master (
        input  ready, level, path, out_chan, out_valid,
        output in_valid, sample, in_chan, cfg_we, cfg_node, cfg_sel, cfg_data
    );

    modport slave (
        output ready, level, path, out_chan, out_valid,
        input  in_valid, sample, in_chan, cfg_we, cfg_node, cfg_sel, cfg_data
    );
endinterface

// File: rtl/dtree_multi.sv
// Multi-feature decision-tree classifier: one signed MAC per cycle per tree level.
// Define DTREE_EARLY_EXIT_EN to stop evaluation on nodes flagged as leaves.
module dtree_multi #(
    parameter int FEATURES    = 3,
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4,
    parameter int DEPTH       = 2,
    parameter int CHAN_WIDTH  = 2
) (
    input logic           clk,
    input logic           reset,
    dtree_multi_if.slave  bus
);
    localparam int NODES  = (1 << DEPTH) - 1;
    localparam int ACC_W  = IN_WIDTH + COEFF_WIDTH + $clog2(FEATURES) + 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SEL_W  = $clog2(FEATURES + 2);
    localparam int K_W    = (FEATURES > 1) ? $clog2(FEATURES) : 1;

    typedef enum logic [1:0] {LOAD, EVAL, DONE} state_t;

    state_t                        state;
    logic [K_W-1:0]                idx;
    logic [NODE_W-1:0]             node;
    logic [LVL_W-1:0]              lvl_cnt;
    logic [DEPTH-1:0]              path_work;
    logic [CHAN_WIDTH-1:0]         chan_work;
    logic signed [ACC_W-1:0]       acc;

    logic [IN_WIDTH-1:0]           feat_buf [FEATURES];
    logic signed [COEFF_WIDTH-1:0] coef     [NODES][FEATURES];
    logic signed [ACC_W-1:0]       thr      [NODES];
    logic [NODES-1:0]              leaf;

    logic                          hs;
    logic signed [ACC_W-1:0]       coef_ext, feat_ext, acc_sum;
    logic                          dec_bit, last_idx, stop, root_leaf, next_leaf;
    logic [NODE_W-1:0]             next_node;
    logic [LVL_W-1:0]              lvl_next;
    logic [DEPTH-1:0]              path_next;

    assign bus.ready = reset && (state == LOAD);
    assign hs        = bus.ready && bus.in_valid;

    // NOTE: every always_comb output is assigned unconditionally, so no latches are inferred.
    always_comb begin
        coef_ext  = ACC_W'(coef[node][idx]);
        feat_ext  = $signed(ACC_W'(feat_buf[idx]));
        acc_sum   = acc + coef_ext * feat_ext;
        dec_bit   = (acc_sum >= thr[node]);
        next_node = NODE_W'(2 * int'(node) + 1 + int'(dec_bit));
        lvl_next  = lvl_cnt + LVL_W'(1);
        path_next = path_work | (DEPTH'(dec_bit) << lvl_cnt);
        last_idx  = (idx == K_W'(FEATURES - 1));
    end

`ifdef DTREE_EARLY_EXIT_EN
    assign root_leaf = leaf[0];
    assign next_leaf = (lvl_next != LVL_W'(DEPTH)) && leaf[next_node];
`else
    logic unused_leaf;
    assign unused_leaf = ^leaf;
    assign root_leaf   = 1'b0;
    assign next_leaf   = 1'b0;
`endif

    assign stop = (lvl_next == LVL_W'(DEPTH)) || next_leaf;

    // NOTE: the feature buffer is fully rewritten before every evaluation, so it carries no reset;
    // the node table below is architectural state and is cleared.
    always_ff @(posedge clk) begin
        if (hs) feat_buf[idx] <= bus.sample;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NODES; n++) begin
                thr[n] <= '0;
                for (int k = 0; k < FEATURES; k++) coef[n][k] <= '0;
            end
            leaf <= '0;
        end else if (bus.cfg_we && state == LOAD && bus.cfg_node < NODE_W'(NODES)
                     && {1'b0, bus.cfg_sel} < (SEL_W + 1)'(FEATURES + 2)) begin
            if (bus.cfg_sel < SEL_W'(FEATURES))
                coef[bus.cfg_node][bus.cfg_sel] <= bus.cfg_data[COEFF_WIDTH-1:0];
            else if (bus.cfg_sel == SEL_W'(FEATURES))
                thr[bus.cfg_node] <= bus.cfg_data;
            else
                leaf[bus.cfg_node] <= bus.cfg_data[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= LOAD;
            idx           <= '0;
            node          <= '0;
            lvl_cnt       <= '0;
            path_work     <= '0;
            chan_work     <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.level     <= '0;
            bus.path      <= '0;
            bus.out_chan  <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            unique case (state)
                LOAD: if (hs) begin
                    if (idx == '0) chan_work <= bus.in_chan;
                    if (last_idx) begin
                        idx       <= '0;
                        node      <= '0;
                        lvl_cnt   <= '0;
                        path_work <= '0;
                        acc       <= '0;
                        if (root_leaf) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.level     <= '0;
                            bus.path      <= '0;
                            bus.out_chan  <= (idx == '0) ? bus.in_chan : chan_work;
                        end else begin
                            state <= EVAL;
                        end
                    end else begin
                        idx <= idx + K_W'(1);
                    end
                end
                EVAL: begin
                    if (last_idx) begin
                        idx <= '0;
                        acc <= '0;
                        if (stop) begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.level     <= lvl_next;
                            bus.path      <= path_next;
                            bus.out_chan  <= chan_work;
                        end else begin
                            node      <= next_node;
                            lvl_cnt   <= lvl_next;
                            path_work <= path_next;
                        end
                    end else begin
                        idx <= idx + K_W'(1);
                        acc <= acc_sum;
                    end
                end
                DONE:    state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_dtree_multi.sv
// Scoreboard bench for dtree_multi: driver pushes model results, monitor pops on out_valid.
module tb_dtree_multi;
    localparam int FEATURES    = 3;
    localparam int IN_WIDTH    = 10;
    localparam int COEFF_WIDTH = 4;
    localparam int DEPTH       = 2;
    localparam int CHAN_WIDTH  = 2;
    localparam int NODES       = (1 << DEPTH) - 1;
    localparam int ACC_W       = IN_WIDTH + COEFF_WIDTH + $clog2(FEATURES) + 1;
    localparam int NODE_W      = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int SEL_W       = $clog2(FEATURES + 2);
`ifdef DTREE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dtree_multi_if #(.FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
                     .DEPTH(DEPTH), .CHAN_WIDTH(CHAN_WIDTH)) bus ();

    dtree_multi #(.FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .COEFF_WIDTH(COEFF_WIDTH),
                  .DEPTH(DEPTH), .CHAN_WIDTH(CHAN_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int level;
        int path;
        int chan;
        int hs_cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_coef [NODES][FEATURES];
    int   m_thr  [NODES];
    bit   m_leaf [NODES];
    int   cur_feat [FEATURES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Walk the tree directly from the configured table with integer arithmetic.
    function automatic void model(output int lv, output int pth);
        int nd;
        int acc;
        bit b;
        nd = 0; lv = 0; pth = 0;
        while (lv < DEPTH) begin
            if (EARLY && m_leaf[nd]) break;
            acc = 0;
            for (int k = 0; k < FEATURES; k++) acc += m_coef[nd][k] * cur_feat[k];
            b = (acc >= m_thr[nd]);
            pth |= int'(b) << lv;
            lv++;
            nd = 2 * nd + 1 + int'(b);
        end
    endfunction

    function automatic void model_cfg(input int nd, input int sel, input int data);
        logic [ACC_W-1:0]              d;
        logic signed [COEFF_WIDTH-1:0] c;
        logic signed [ACC_W-1:0]       t;
        d = ACC_W'(data);
        c = d[COEFF_WIDTH-1:0];
        t = d;
        if (sel < FEATURES)       m_coef[nd][sel] = int'(c);
        else if (sel == FEATURES) m_thr[nd] = int'(t);
        else                      m_leaf[nd] = d[0];
    endfunction

    function automatic void clear_model();
        for (int n = 0; n < NODES; n++) begin
            m_thr[n] = 0;
            m_leaf[n] = 1'b0;
            for (int k = 0; k < FEATURES; k++) m_coef[n][k] = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (reset && bus.out_valid === 1'b1) begin
            check("out_valid_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("level",    bus.level,    mon_e.level);
                check("path",     bus.path,     mon_e.path);
                check("out_chan", bus.out_chan, mon_e.chan);
                check("latency",  cyc - mon_e.hs_cyc, mon_e.lat);
            end
        end
    end

    task automatic cfg_write(input int nd, input int sel, input int data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_node = NODE_W'(nd);
        bus.cfg_sel  = SEL_W'(sel);
        bus.cfg_data = ACC_W'(data);
        if (bus.ready && nd < NODES && sel < FEATURES + 2) model_cfg(nd, sel, data);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic send_set(input int chan, input bit hold, input int max_gap);
        int lv, pth, budget, gap;
        for (int i = 0; i < FEATURES; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            repeat (gap) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.sample   = IN_WIDTH'(cur_feat[i]);
            bus.in_chan  = (i == 0) ? CHAN_WIDTH'(chan) : CHAN_WIDTH'($urandom);
            budget = 0;
            while (!bus.ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 100) check("ready_timeout", bus.ready, 1);
            if (i == FEATURES - 1) begin
                model(lv, pth);
                sb.push_back('{level: lv, path: pth, chan: chan, hs_cyc: cyc, lat: lv * FEATURES + 1});
            end
        end
        @(negedge clk);
        if (!hold) begin
            bus.in_valid = 1'b0;
        end else begin
            // Keep offering features and rewrite the root threshold while busy.
            bus.sample   = IN_WIDTH'($urandom);
            bus.cfg_we   = 1'b1;
            bus.cfg_node = '0;
            bus.cfg_sel  = SEL_W'(FEATURES);
            bus.cfg_data = ACC_W'($urandom);
            budget = 0;
            while (!bus.out_valid && budget < 100) begin
                @(negedge clk);
                bus.cfg_we = 1'b0;
                budget++;
            end
            if (budget >= 100) check("out_valid_timeout", bus.out_valid, 1);
            bus.in_valid = 1'b0;
            bus.cfg_we   = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (sb.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) check("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_ready",     bus.ready,     0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_level",     bus.level,     0);
        check("rst_path",      bus.path,      0);
        check("rst_out_chan",  bus.out_chan,  0);
        reset = 1'b1;
        #1;
        check("ready_after_release", bus.ready, 1);
    endtask

    task automatic set_feat(input int f0, input int f1, input int f2);
        cur_feat[0] = f0;
        cur_feat[1] = f1;
        cur_feat[2] = f2;
    endtask

    task automatic run_random(input int iters);
        int nw, nd, sel, data;
        for (int it = 0; it < iters; it++) begin
            nw = $urandom_range(4);
            for (int w = 0; w < nw; w++) begin
                nd  = $urandom_range(NODES);
                sel = $urandom_range(7);
                if (sel < FEATURES)       data = int'($urandom);
                else if (sel == FEATURES) data = int'($urandom_range(60000)) - 30000;
                else if (sel == FEATURES + 1) data = ($urandom_range(3) == 0) ? 1 : 0;
                else                      data = int'($urandom);
                cfg_write(nd, sel, data);
            end
            for (int k = 0; k < FEATURES; k++) cur_feat[k] = $urandom_range(1023);
            send_set($urandom_range(3), $urandom_range(4) == 0, 2);
            if ($urandom_range(1) == 1) wait_drain();
        end
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.sample   = '0;
        bus.in_chan  = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_node = '0;
        bus.cfg_sel  = '0;
        bus.cfg_data = '0;
        clear_model();
        do_reset();

        // Two-level path: root right, then node 2 left.
        cfg_write(0, 0, 1);
        cfg_write(0, FEATURES, 100);
        cfg_write(2, 1, 1);
        cfg_write(2, FEATURES, 50);
        set_feat(150, 10, 0);
        send_set(2, 1'b0, 0);
        wait_drain();
        check("basic_path",  bus.path,  1);
        check("basic_level", bus.level, 2);

        // Negative coefficient at full-scale sample against a negative threshold.
        cfg_write(0, 0, 0);
        cfg_write(0, 1, -8);
        cfg_write(0, FEATURES, -8000);
        set_feat(0, 1023, 0);
        send_set(1, 1'b0, 0);
        wait_drain();
        check("neg_path",  bus.path,  2);
        check("neg_level", bus.level, 2);

        // Leaf at the root's left child.
        cfg_write(1, FEATURES + 1, 1);
        send_set(0, 1'b0, 0);
        wait_drain();
        check("leaf_level", bus.level, EARLY ? 1 : 2);
        check("leaf_path",  bus.path,  EARLY ? 0 : 2);
        cfg_write(1, FEATURES + 1, 0);

        // Out-of-range configuration writes must be dropped.
        cfg_write(3, 0, 7);
        cfg_write(0, FEATURES + 2, 5);
        cfg_write(0, 7, 3);
        set_feat(500, 20, 900);
        send_set(3, 1'b0, 1);
        wait_drain();

        // Back-to-back sets with different channel tags.
        set_feat(150, 10, 0);
        send_set(3, 1'b0, 0);
        set_feat(0, 1023, 0);
        send_set(1, 1'b0, 0);
        wait_drain();
        check("b2b_out_chan", bus.out_chan, 1);

        // Held in_valid and a threshold write while busy; the following set must be clean.
        set_feat(150, 10, 0);
        send_set(2, 1'b1, 0);
        set_feat(0, 1023, 0);
        send_set(0, 1'b0, 0);
        wait_drain();

        // Reset in the middle of an evaluation aborts it.
        set_feat(150, 10, 0);
        send_set(2, 1'b0, 0);
        @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check("abort_level", bus.level, 0);
        check("abort_path",  bus.path,  0);
        cfg_write(0, 0, 1);
        cfg_write(0, FEATURES, 100);
        cfg_write(2, 1, 1);
        cfg_write(2, FEATURES, 50);
        send_set(1, 1'b0, 0);
        wait_drain();
        check("post_abort_path", bus.path, 1);

        run_random(40);
        check("final_queue_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dtree_multi.md
DTREE_MULTI -- requirements
Module: dtree_multi

Interface
REQ-001 Parameter FEATURES, default 3: number of features per classification.
REQ-002 Parameter IN_WIDTH, default 10: unsigned sample width.
REQ-003 Parameter COEFF_WIDTH, default 4: signed coefficient width.
REQ-004 Parameter DEPTH, default 2: maximum tree depth; node table holds 2^DEPTH-1 nodes.
REQ-005 Parameter CHAN_WIDTH, default 2: channel tag width.
REQ-006 Derived ACC_W = IN_WIDTH+COEFF_WIDTH+clog2(FEATURES)+1; LVL_W = clog2(DEPTH+1).
REQ-007 clk  input  1  sole clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 ready  output  1  block accepts a feature this cycle.
REQ-010 in_valid  input  1  sample and in_chan valid.
REQ-011 sample  input  IN_WIDTH  feature value, unsigned.
REQ-012 in_chan  input  CHAN_WIDTH  channel tag, sampled with feature 0 only.
REQ-013 cfg_we  input  1  node-table write strobe.
REQ-014 cfg_node  input  clog2(2^DEPTH-1)  node index.
REQ-015 cfg_sel  input  clog2(FEATURES+2)  field: 0..FEATURES-1 coefficient, FEATURES threshold, FEATURES+1 leaf flag.
REQ-016 cfg_data  input  ACC_W  write data; coefficients take low COEFF_WIDTH bits, leaf flag takes bit 0.
REQ-017 level  output  LVL_W  number of decisions taken.
REQ-018 path  output  DEPTH  decision bits; bit i = decision at level i.
REQ-019 out_chan  output  CHAN_WIDTH  tag of classified feature set.
REQ-020 out_valid  output  1  single-cycle result strobe.

Function
REQ-021 FSM states LOAD, EVAL, DONE; LOAD->EVAL on handshake of feature FEATURES-1; EVAL->DONE when the final level completes; DONE->LOAD after one cycle.
REQ-022 ready = 1 only in LOAD; handshake = ready & in_valid; in_valid while ready = 0 ignored.
REQ-023 Features stored in order of handshake into a FEATURES-entry buffer; feature count resets to 0 on entry to LOAD.
REQ-024 EVAL: one signed multiply-accumulate per cycle (coeff[node][k] x zero-extended feature k); each level takes exactly FEATURES cycles.
REQ-025 Decision on the last accumulate of a level: acc >= threshold -> bit 1 (right), else bit 0 (left); acc cleared for next level.
REQ-026 Root node 0; next node = 2*node+1+bit.
REQ-027 EVAL ends after DEPTH levels, or earlier per REQ-036.
REQ-028 DONE: out_valid = 1 for exactly one cycle; level, path, out_chan hold until next DONE; unused path bits = 0.
REQ-029 Latency: out_valid asserts L*FEATURES+1 cycles after last feature handshake, L = levels evaluated.
REQ-030 cfg writes take effect in LOAD only; writes in EVAL/DONE dropped silently; out-of-range cfg_node or cfg_sel dropped.
REQ-031 No overflow possible in ACC_W; no saturation logic.

Reset
REQ-032 On reset low: state LOAD, ready 0 while asserted then 1 the first cycle after release, out_valid 0, level 0, path 0, out_chan 0, feature count 0, acc 0.
REQ-033 Node table (coefficients, thresholds, leaf flags) cleared to 0 on reset.
REQ-034 Reset mid-EVAL or mid-LOAD aborts the operation; no out_valid for the aborted set.

Configuration
REQ-035 Macro DTREE_EARLY_EXIT_EN selects leaf handling.
REQ-036 Defined: a node with leaf flag 1 terminates EVAL on reaching it without evaluation; level = decisions taken so far.
REQ-037 Undefined: leaf flags stored but ignored; always DEPTH levels; level = DEPTH.

Verification (defaults; node 2 = root's right child)
REQ-038 Root coeffs (1,0,0) thr 100; node 2 coeffs (0,1,0) thr 50; samples 150,10,0 -> path 2'b01, level 2, out_valid 7 cycles after last handshake.
REQ-039 Root coeffs (0,-8,0) thr -8000; samples 0,1023,0 -> acc -8184, bit0 = 0, next node 1.
REQ-040 DTREE_EARLY_EXIT_EN defined, node 1 leaf, root sends left -> level 1, path 2'b00, latency 4; undefined -> level 2, latency 7.
REQ-041 Reset pulsed 2 cycles into EVAL -> no out_valid; outputs 0; next set classifies correctly.
REQ-042 cfg_we to root threshold during EVAL -> ignored, result unchanged; in_valid held high during EVAL -> no extra features captured.
REQ-043 Two back-to-back sets with in_chan 3 then 1 -> out_chan 3 then 1, one out_valid each.
